alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
- REQ-001 SHALL have parameter WIDTH, default 16, the operand and result width in bits.
- REQ-002 SHALL have parameter TAG_W, default 3, the destination-tag width in bits.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-005 SHALL have port in_valid, input, 1 bit: upstream request valid.
- REQ-006 SHALL have port in_ready, output, 1 bit: stage can accept a request.
- REQ-007 SHALL have port in_op, input, 3 bits: operation code.
- REQ-008 SHALL have ports in_a and in_b, input, WIDTH bits each: operands.
- REQ-009 SHALL have port in_tag, input, TAG_W bits: destination register tag, passed through unchanged.
- REQ-010 SHALL have port out_valid, output, 1 bit: result valid.
- REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
- REQ-012 SHALL have port out_result, output, WIDTH bits: operation result.
- REQ-013 SHALL have port out_tag, output, TAG_W bits: tag of the result.
- REQ-014 SHALL have port out_flags, output, 4 bits {V,C,N,Z}, present only when ALU_FLAGS_EN is defined.

Function
- REQ-015 SHALL decode in_op as follows:
  - 000 add, 001 and, 010 or, 011 xor
  - 100 sub (a-b), 101 nand, 110 nor, 111 xnor
- REQ-016 SHALL compute add and sub modulo 2^WIDTH.
- REQ-017 SHALL be a two-register pipeline:
  - S1 holds the operand register plus a valid bit.
  - The combinational ALU sits between S1 and S2.
  - S2 holds the result register plus a valid bit.
- REQ-018 SHALL accept a request on a cycle where in_valid && in_ready, and no other request.
- REQ-019 SHALL assert out_valid exactly 2 cycles after acceptance when there is no stall.
- REQ-020 SHALL sustain 1 result per cycle when out_ready is held high.
- REQ-021 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready, combinationally.
- REQ-022 SHALL hold out_result, out_tag and out_flags stable while out_valid && !out_ready.
- REQ-023 SHALL, when out_valid && out_ready and S1 is empty, clear s2_valid on the next edge.
- REQ-024 SHALL, when out_valid && out_ready and S1 is valid, load S1's result into S2 on the same edge.
- REQ-025 SHALL, when accept and S1 advance occur on the same edge, load the new request into S1 with no bubble.
- REQ-026 SHALL never drop or duplicate a request.
- REQ-027 SHALL deliver results in acceptance order.
- REQ-028 SHALL compute the flags as follows:
  - Z = result==0.
  - N = result MSB.
  - C = carry-out for add; C = NOT borrow (a >= b unsigned) for sub; C = 0 for logic ops.
  - V = two's-complement overflow for add/sub; V = 0 for logic ops.

Reset
- REQ-029 SHALL, when rst_n is low, immediately clear s1_valid and s2_valid to 0.
- REQ-030 SHALL, when rst_n is low, immediately clear out_result, out_tag and out_flags to 0.
- REQ-031 SHALL output in_ready=1 and out_valid=0 during reset.
- REQ-032 SHALL discard in-flight requests on reset mid-operation; they are never delivered.
- REQ-033 SHALL accept a request on the first rising edge after rst_n is deasserted.

Configuration
- REQ-034 SHALL, when ALU_FLAGS_EN is defined, compute and register out_flags alongside out_result.
- REQ-035 SHALL, when ALU_FLAGS_EN is undefined, omit the out_flags port and its registers; all other behaviour is identical.

Structure
- REQ-036 SHALL take opcode enumeration, flag bit indices (Z=0, N=1, C=2, V=3) and default WIDTH from shared package alu_pkg.
- REQ-037 SHALL instantiate one combinational sub-module, alu_core (a, b, op -> result, carry, overflow), between S1 and S2.

Verification
- REQ-038 SHALL cover, with out_ready=1: send add 0x2003+0x4006, tag 5 -> out_valid 2 cycles later, result 0x6009, tag 5, flags 0000.
- REQ-039 SHALL cover: sub 0x0003-0x0005 -> result 0xFFFE, N=1, C=0, Z=0; sub 0x8000-0x0001 -> 0x7FFF, V=1, C=1.
- REQ-040 SHALL cover: 64 back-to-back ops (all 8 opcodes × 8 operand pairs, operands stepped by 8195) -> one result per cycle, in order, each matching the reference model.
- REQ-041 SHALL cover: hold out_ready=0 for 5 cycles while sending 4 requests -> in_ready drops after 2 accepted, outputs stay stable, then all accepted requests drain in order after release.
- REQ-042 SHALL cover: assert rst_n low while S1 and S2 are both valid -> out_valid=0 immediately, no stale result after release, first new request completes in 2 cycles.
- REQ-043 SHALL cover: xnor 0xFFFF,0xFFFF with ALU_FLAGS_EN defined -> result 0xFFFF, flags N=1, C=V=Z=0; the same bench compiled without the macro passes minus the flag checks.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, flag bit positions and default datapath width.
// Flag vector layout is {V,C,N,Z}, indexed by the FLAG_* constants.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_SUB  = 3'b100,
        OP_NAND = 3'b101,
        OP_NOR  = 3'b110,
        OP_XNOR = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus carry/overflow; zero latency, no flow control.
// Sub computes a + ~b + 1 so carry reads as NOT borrow; logic ops report carry = overflow = 0.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result   = diff[WIDTH-1:0];
                carry    = diff[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XNOR: result = ~(a ^ b);
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-register ALU pipeline (operands -> alu_core -> result); latency 2 cycles, 1 result/cycle.
// Valid/ready backpressure, in_ready = !s1_valid || !s2_valid || out_ready; ALU_FLAGS_EN adds out_flags {V,C,N,Z}.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]       out_flags
`endif
);

    typedef struct packed {
        alu_op_e          op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } s1_t;

    s1_t              s1_q;
    logic             s1_valid;
    logic             s2_valid;
    logic             s2_adv;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;

    // S2 can take a new value when it is empty or its current result leaves this cycle.
    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= '{op: alu_op_e'(in_op), a: in_a, b: in_b, tag: in_tag};
            end
        end
    end

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a       (s1_q.a),
        .b       (s1_q.b),
        .op      (s1_q.op),
        .result  (alu_res),
        .carry   (alu_carry),
        .overflow(alu_ovf)
    );

`ifdef ALU_FLAGS_EN
    logic [3:0] flags_nxt;

    always_comb begin
        flags_nxt         = '0;
        flags_nxt[FLAG_Z] = (alu_res == '0);
        flags_nxt[FLAG_N] = alu_res[WIDTH-1];
        flags_nxt[FLAG_C] = alu_carry;
        flags_nxt[FLAG_V] = alu_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flags <= '0;
        end else if (s2_adv && s1_valid) begin
            out_flags <= flags_nxt;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = alu_carry ^ alu_ovf;
`endif

    // Result registers only change when a new S1 entry moves in, so they hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= alu_res;
                out_tag    <= s1_q.tag;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: stimulus pushes expected results, a negedge monitor pops and compares.
// Flag checks are compiled in only when ALU_FLAGS_EN is defined.
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_tag;
`ifdef ALU_FLAGS_EN
    logic [3:0]  out_flags;
`endif

    always #5 clk = ~clk;

    alu_exec_stage #(
        .WIDTH(16),
        .TAG_W(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_tag   (out_tag)
`ifdef ALU_FLAGS_EN
        ,
        .out_flags (out_flags)
`endif
    );

    typedef struct {
        logic [15:0] res;
        logic [2:0]  tag;
        logic [3:0]  flags;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    int   n_out  = 0;
    int   n_acc  = 0;
    int   n_disc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model in plain integer arithmetic; flags returned as {V,C,N,Z}.
    function automatic void ref_calc(input int op, input int a, input int b,
                                     output logic [15:0] res, output logic [3:0] fl);
        int r, sa, sbv, ss;
        bit c, v;
        c   = 1'b0;
        v   = 1'b0;
        r   = 0;
        sa  = (a >= 32768) ? a - 65536 : a;
        sbv = (b >= 32768) ? b - 65536 : b;
        case (op)
            0: begin r = a + b; c = (r > 65535); ss = sa + sbv; v = (ss > 32767) || (ss < -32768); end
            4: begin r = a - b; c = (a >= b);    ss = sa - sbv; v = (ss > 32767) || (ss < -32768); end
            1: r = a & b;
            2: r = a | b;
            3: r = a ^ b;
            5: r = ~(a & b);
            6: r = ~(a | b);
            default: r = ~(a ^ b);
        endcase
        res = r[15:0];
        fl  = {v, c, res[15], res == 16'h0000};
    endfunction

    // Called at posedge+1; in_ready is sampled at posedge+2 so it reflects the state before the next edge.
    task automatic send(input int op, input int a, input int b, input int tag,
                        input logic [15:0] eres, input logic [3:0] efl, input bit lat);
        logic ok;
        in_valid = 1'b1;
        in_op    = op[2:0];
        in_a     = a[15:0];
        in_b     = b[15:0];
        in_tag   = tag[2:0];
        for (int t = 0; t < 50; t++) begin
            #1;
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                sb.push_back('{res: eres, tag: tag[2:0], flags: efl, acc: cyc, chk_lat: lat});
                n_acc++;
                in_valid = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_err++;
        in_valid = 1'b0;
        $display("FAIL accept_timeout: tag %0d not accepted within 50 cycles", tag);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 60; t++) begin
            if (sb.size() == 0 && !out_valid) return;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_err++;
        $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
    endtask

    // Monitor: pops on handshake, and while stalled checks the held output against the head entry.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: tag %0d result 0x%0h, expected no output", out_tag, out_result);
            end else begin
                e = sb[0];
                if (out_ready) begin
                    void'(sb.pop_front());
                    n_out++;
                    chk("result", out_result, e.res);
                    chk("tag", out_tag, e.tag);
`ifdef ALU_FLAGS_EN
                    chk("flags", out_flags, e.flags);
`endif
                    if (e.chk_lat) chk("latency_cycles", cyc - e.acc + 1, 2);
                end else begin
                    chk("stall_result", out_result, e.res);
                    chk("stall_tag", out_tag, e.tag);
`ifdef ALU_FLAGS_EN
                    chk("stall_flags", out_flags, e.flags);
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #2;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_result", out_result, 0);
        chk("reset_out_tag", out_tag, 0);
`ifdef ALU_FLAGS_EN
        chk("reset_out_flags", out_flags, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors, hand-computed expectations, flags {V,C,N,Z}.
        send(0, 'h2003, 'h4006, 5, 16'h6009, 4'b0000, 1'b1);
        send(4, 'h0003, 'h0005, 2, 16'hFFFE, 4'b0010, 1'b1);
        send(4, 'h8000, 'h0001, 3, 16'h7FFF, 4'b1100, 1'b1);
        send(7, 'hFFFF, 'hFFFF, 6, 16'hFFFF, 4'b0010, 1'b1);
        send(1, 'h00F0, 'h0F00, 1, 16'h0000, 4'b0001, 1'b1);
        send(0, 'hFFFF, 'h0001, 4, 16'h0000, 4'b0101, 1'b1);
        wait_drain();

        // 64 back-to-back operations: all opcodes across 8 operand pairs.
        start = cyc;
        for (int op = 0; op < 8; op++) begin
            for (int j = 0; j < 8; j++) begin
                int a, b;
                logic [15:0] r;
                logic [3:0]  f;
                a = (j * 8195) & 'hFFFF;
                b = ((j + 3) * 8195) & 'hFFFF;
                ref_calc(op, a, b, r, f);
                send(op, a, b, (op + j) & 7, r, f, 1'b1);
            end
        end
        chk("b2b_accept_cycles", cyc - start, 64);
        wait_drain();

        // Downstream stall for 5 cycles while offering 4 requests.
        out_ready = 1'b0;
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin
                send(2, 'h1200, 'h0034, 1, 16'h1234, 4'b0000, 1'b0);
                send(3, 'hAAAA, 'h5555, 2, 16'hFFFF, 4'b0010, 1'b0);
                @(negedge clk);
                chk("stall_in_ready", in_ready, 0);
                @(posedge clk);
                #1;
                send(5, 'hFFFF, 'h0000, 3, 16'hFFFF, 4'b0010, 1'b0);
                send(6, 'h0000, 'h0000, 4, 16'hFFFF, 4'b0010, 1'b0);
            end
        join
        wait_drain();

        // Reset while both stages hold data; those results must never appear.
        out_ready = 1'b0;
        send(0, 'h0001, 'h0001, 1, 16'h0002, 4'b0000, 1'b0);
        send(0, 'h0002, 'h0002, 2, 16'h0004, 4'b0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_in_ready", in_ready, 1);
        chk("midreset_out_result", out_result, 0);
        chk("midreset_out_tag", out_tag, 0);
        n_disc += sb.size();
        sb.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(4, 'h0010, 'h0001, 7, 16'h000F, 4'b0100, 1'b1);
        wait_drain();

        chk("delivered_count", n_out, n_acc - n_disc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
